// File: rtl/latch_bank_arbiter.sv
// Two-requester, round-robin arbiter that drives a bank of 2**AW level latches.
// Each write runs SETUP (data on D) -> PULSE (one C line high) -> HOLD (done) -> IDLE.
module latch_bank_arbiter #(
    parameter int DW = 8,
    parameter int AW = 2
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 req0,
    input  logic [AW-1:0]        addr0,
    input  logic [DW-1:0]        data0,
    input  logic                 req1,
    input  logic [AW-1:0]        addr1,
    input  logic [DW-1:0]        data1,
    output logic                 gnt0,
    output logic                 gnt1,
    output logic                 done0,
    output logic                 done1,
    output logic [(2**AW)-1:0]   latch_c,
    output logic [DW-1:0]        latch_d,
    output logic                 busy
);

    localparam int NL = 2**AW;

    typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;

    state_t          state_reg;
    logic            last_reg;      // requester served most recently (1 after reset so 0 wins first)
    logic [AW-1:0]   addr_reg;
    logic [DW-1:0]   data_reg;
    logic            gnt0_reg;
    logic            gnt1_reg;
    logic            done0_reg;
    logic            done1_reg;
    logic            busy_reg;
    logic [NL-1:0]   latch_c_reg;
    logic [NL-1:0]   sel_onehot;
    logic            win_next;

    // Contention goes to whoever was not served last; a lone request always wins.
    assign win_next = (req0 && req1) ? ~last_reg : req1;

    generate
        for (genvar gi = 0; gi < NL; gi++) begin : g_dec
            assign sel_onehot[gi] = (addr_reg == AW'(gi));
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg   <= IDLE;
            last_reg    <= 1'b1;
            addr_reg    <= '0;
            data_reg    <= '0;
            gnt0_reg    <= 1'b0;
            gnt1_reg    <= 1'b0;
            done0_reg   <= 1'b0;
            done1_reg   <= 1'b0;
            busy_reg    <= 1'b0;
            latch_c_reg <= '0;
        end else begin
            case (state_reg)
                IDLE: begin
                    if (req0 || req1) begin
                        state_reg <= SETUP;
                        last_reg  <= win_next;
                        addr_reg  <= win_next ? addr1 : addr0;
                        data_reg  <= win_next ? data1 : data0;
                        gnt0_reg  <= ~win_next;
                        gnt1_reg  <= win_next;
                        busy_reg  <= 1'b1;
                    end
                end
                SETUP: begin
                    state_reg   <= PULSE;
                    latch_c_reg <= sel_onehot;
                end
                PULSE: begin
                    state_reg   <= HOLD;
                    latch_c_reg <= '0;
                    done0_reg   <= gnt0_reg;
                    done1_reg   <= gnt1_reg;
                end
                HOLD: begin
                    state_reg <= IDLE;
                    done0_reg <= 1'b0;
                    done1_reg <= 1'b0;
                    gnt0_reg  <= 1'b0;
                    gnt1_reg  <= 1'b0;
                    busy_reg  <= 1'b0;
                end
                default: state_reg <= IDLE;
            endcase
        end
    end

    assign gnt0    = gnt0_reg;
    assign gnt1    = gnt1_reg;
    assign done0   = done0_reg;
    assign done1   = done1_reg;
    assign latch_c = latch_c_reg;
    assign latch_d = data_reg;   // D bus keeps the last captured value while idle
    assign busy    = busy_reg;

endmodule

// File: tb/tb_latch_bank_arbiter.sv
// Bench for latch_bank_arbiter: transaction-level reference model checked every
// cycle, directed scenarios with literal expectations, then randomized traffic.
module tb_latch_bank_arbiter;

    localparam int DW = 8;
    localparam int AW = 2;
    localparam int NL = 2**AW;

    logic            clk = 1'b0;
    logic            rst = 1'b1;
    logic            req0 = 1'b0, req1 = 1'b0;
    logic [AW-1:0]   addr0 = '0, addr1 = '0;
    logic [DW-1:0]   data0 = '0, data1 = '0;
    logic            gnt0, gnt1, done0, done1, busy;
    logic [NL-1:0]   latch_c;
    logic [DW-1:0]   latch_d;

    int errors = 0;
    int checks = 0;
    bit check_en = 0;

    latch_bank_arbiter #(.DW(DW), .AW(AW)) dut (
        .clk(clk), .rst(rst),
        .req0(req0), .addr0(addr0), .data0(data0),
        .req1(req1), .addr1(addr1), .data1(data1),
        .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
        .latch_c(latch_c), .latch_d(latch_d), .busy(busy)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
        end
    endtask

    // Reference model: a transaction is "cycle m of 3" after acceptance (m=0 means idle).
    int              m_ph   = 0;
    int              m_win  = 0;
    int              m_last = 1;
    logic [AW-1:0]   m_addr = '0;
    logic [DW-1:0]   m_d    = '0;

    always @(posedge clk) begin
        if (rst) begin
            m_ph = 0; m_last = 1; m_d = '0;
            check_en = 1;
        end else if (m_ph == 0) begin
            if (req0 || req1) begin
                if (req0 && req1) m_win = 1 - m_last;
                else              m_win = req1 ? 1 : 0;
                m_last = m_win;
                m_addr = (m_win == 1) ? addr1 : addr0;
                m_d    = (m_win == 1) ? data1 : data0;
                m_ph   = 1;
            end
        end else begin
            m_ph = (m_ph + 1) % 4;
        end
    end

    always @(negedge clk) begin
        if (check_en) begin
            logic [NL-1:0] exp_c;
            exp_c = (m_ph == 2) ? NL'(1 << m_addr) : '0;
            check("model_gnt0", gnt0, (m_ph != 0 && m_win == 0));
            check("model_gnt1", gnt1, (m_ph != 0 && m_win == 1));
            check("model_done0", done0, (m_ph == 3 && m_win == 0));
            check("model_done1", done1, (m_ph == 3 && m_win == 1));
            check("model_busy", busy, (m_ph != 0));
            check("model_latch_c", latch_c, exp_c);
            check("model_latch_d", latch_d, m_d);
        end
    end

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic do_reset();
        rst = 1'b1; req0 = 0; req1 = 0;
        tick(2);
        rst = 1'b0;
    endtask

    initial begin
        int busy_cnt;
        // Reset state, with requests present on the reset edge that must be ignored.
        req0 = 1; req1 = 1;
        tick(2);
        check("rst_busy", busy, 0);
        check("rst_gnt", {gnt0, gnt1}, 0);
        check("rst_latch_d", latch_d, 0);
        check("rst_latch_c", latch_c, 0);
        do_reset();

        // Single write: addr 2, data A5.
        req0 = 1; addr0 = 2; data0 = 8'hA5;
        tick(1);
        check("w1_gnt0", gnt0, 1);
        check("w1_setup_d", latch_d, 8'hA5);
        check("w1_setup_c", latch_c, 0);
        busy_cnt = busy;
        tick(1);
        check("w1_pulse_c", latch_c, 4'b0100);
        busy_cnt += busy;
        tick(1);
        check("w1_hold_c", latch_c, 0);
        check("w1_done0", done0, 1);
        busy_cnt += busy;
        req0 = 0;
        tick(1);
        check("w1_idle_gnt0", gnt0, 0);
        busy_cnt += busy;
        check("w1_busy_cycles", busy_cnt, 3);
        check("w1_idle_d", latch_d, 8'hA5);
        tick(2);

        // Both held: grants alternate 0,1,0,1 with a 4-cycle period.
        do_reset();
        req0 = 1; addr0 = 1; data0 = 8'h3C;
        req1 = 1; addr1 = 3; data1 = 8'hC3;
        for (int t = 0; t < 4; t++) begin
            tick(1);
            check("rr_gnt", {gnt1, gnt0}, (t % 2 == 0) ? 2'b01 : 2'b10);
            tick(1);
            check("rr_pulse", latch_c, (t % 2 == 0) ? 4'b0010 : 4'b1000);
            tick(2);
            check("rr_idle_busy", busy, 0);
        end
        req0 = 0; req1 = 0;
        tick(4);

        // Requester data changing during SETUP must not reach the D bus.
        req0 = 1; addr0 = 0; data0 = 8'h11;
        tick(1);
        data0 = 8'hFF;
        for (int i = 0; i < 3; i++) begin
            check("hold_d", latch_d, 8'h11);
            tick(1);
        end
        req0 = 0;
        tick(2);

        // Reset during PULSE: no done, then req1 served with normal timing.
        req0 = 1; addr0 = 3; data0 = 8'h5A;
        tick(2);
        check("rp_in_pulse", latch_c, 4'b1000);
        rst = 1; req0 = 0;
        tick(1);
        check("rp_c", latch_c, 0);
        check("rp_gnt", {gnt0, gnt1}, 0);
        check("rp_busy", busy, 0);
        check("rp_done", {done0, done1}, 0);
        rst = 0; req1 = 1; addr1 = 1; data1 = 8'h77;
        tick(1);
        check("rp_gnt1", gnt1, 1);
        check("rp_d", latch_d, 8'h77);
        req1 = 0;   // dropped during SETUP: must still complete
        tick(1);
        check("drop_pulse", latch_c, 4'b0010);
        tick(1);
        check("drop_done1", done1, 1);
        tick(1);
        for (int i = 0; i < 3; i++) begin
            check("drop_idle", busy, 0);
            tick(1);
        end

        // Randomized traffic, occasional resets.
        for (int i = 0; i < 3000; i++) begin
            rst   = ($urandom_range(0, 99) == 0);
            req0  = ($urandom_range(0, 2) != 0);
            req1  = ($urandom_range(0, 2) != 0);
            addr0 = AW'($urandom);
            addr1 = AW'($urandom);
            data0 = DW'($urandom);
            data1 = DW'($urandom);
            tick(1);
        end
        rst = 0; req0 = 0; req1 = 0;
        tick(6);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
